// File: rtl/line_buf_pkg.sv
// Shared types for the line-buffer frame sequencer.
package line_buf_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCfg,
    StWait,
    StRun,
    StDone
  } state_e;

  localparam int unsigned WAIT_CYCLES = 2;
  localparam int unsigned WAIT_CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

endpackage

// File: rtl/line_buf_ctrl_if.sv
// Config, pixel handshake and delay-memory control bundle for line_buf_ctrl.
interface line_buf_ctrl_if #(
  parameter int unsigned MEM_AWIDTH = 16,
  parameter int unsigned DIM_WIDTH  = 16
);

  logic [MEM_AWIDTH-1:0] cfg_width;
  logic [DIM_WIDTH-1:0]  cfg_height;
  logic                  cfg_start;
  logic                  cfg_abort;
  logic                  cfg_busy;
  logic                  cfg_err;
  logic                  up_val;
  logic                  up_rdy;
  logic [MEM_AWIDTH-1:0] mem_cfg_delay;
  logic                  mem_cfg_set;
  logic                  mem_val;
  logic [MEM_AWIDTH-1:0] col;
  logic [DIM_WIDTH-1:0]  row;
  logic                  win_val;
  logic                  eol;
  logic                  eof;

  modport master (
    output cfg_width, cfg_height, cfg_start, cfg_abort, up_val,
    input  cfg_busy, cfg_err, up_rdy, mem_cfg_delay, mem_cfg_set, mem_val,
    input  col, row, win_val, eol, eof
  );

  modport slave (
    input  cfg_width, cfg_height, cfg_start, cfg_abort, up_val,
    output cfg_busy, cfg_err, up_rdy, mem_cfg_delay, mem_cfg_set, mem_val,
    output col, row, win_val, eol, eof
  );

endinterface

// File: rtl/pix_pos_cnt.sv
// Column/row position counter with end-of-row wrap and last-pixel detect.
module pix_pos_cnt #(
  parameter int unsigned MEM_AWIDTH = 16,
  parameter int unsigned DIM_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  adv_i,
  input  logic [MEM_AWIDTH-1:0] width_m1_i,
  input  logic [DIM_WIDTH-1:0]  height_m1_i,
  output logic [MEM_AWIDTH-1:0] col_o,
  output logic [DIM_WIDTH-1:0]  row_o,
  output logic                  col_last_o,
  output logic                  last_o
);

  logic [MEM_AWIDTH-1:0] col_q, col_d;
  logic [DIM_WIDTH-1:0]  row_q, row_d;

  assign col_o      = col_q;
  assign row_o      = row_q;
  assign col_last_o = (col_q == width_m1_i);
  assign last_o     = col_last_o && (row_q == height_m1_i);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
    end else if (adv_i) begin
      if (col_last_o) begin
        col_d = '0;
        row_d = row_q + DIM_WIDTH'(1);
      end else begin
        col_d = col_q + MEM_AWIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/line_buf_ctrl.sv
// Frame sequencer for a bank of row-delay memories feeding a KERNEL x KERNEL filter.
module line_buf_ctrl
  import line_buf_pkg::*;
#(
  parameter int unsigned MEM_AWIDTH = 16,
  parameter int unsigned DIM_WIDTH  = 16,
  parameter int unsigned KERNEL     = 3
) (
  input logic            clk,
  input logic            rst,
  line_buf_ctrl_if.slave bus
);

  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_q, wait_d;
  logic [MEM_AWIDTH-1:0] width_q, width_d;
  logic [DIM_WIDTH-1:0]  height_q, height_d;
  logic                  err_q, err_d;
  logic                  win_q, win_d;
  logic                  eol_q, eol_d;
  logic                  eof_q, eof_d;

  logic [MEM_AWIDTH-1:0] col;
  logic [DIM_WIDTH-1:0]  row;
  logic                  col_last, pix_last;
  logic                  start_ok, abort, up_rdy, beat, cnt_clr;
  logic [MEM_AWIDTH-1:0] width_m1;
  logic [DIM_WIDTH-1:0]  height_m1;

  assign start_ok  = bus.cfg_start && (bus.cfg_width >= MEM_AWIDTH'(KERNEL))
                     && (bus.cfg_height >= DIM_WIDTH'(KERNEL));
  assign abort     = (state_q != StIdle) && bus.cfg_abort;
  // Abort withdraws ready in the same cycle so no beat lands in a dying frame.
  assign up_rdy    = (state_q == StRun) && !bus.cfg_abort;
  assign beat      = bus.up_val && up_rdy;
  assign cnt_clr   = ((state_q == StIdle) && start_ok) || abort;
  assign width_m1  = width_q - MEM_AWIDTH'(1);
  assign height_m1 = height_q - DIM_WIDTH'(1);

  pix_pos_cnt #(
    .MEM_AWIDTH(MEM_AWIDTH),
    .DIM_WIDTH (DIM_WIDTH)
  ) u_pos (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (cnt_clr),
    .adv_i      (beat),
    .width_m1_i (width_m1),
    .height_m1_i(height_m1),
    .col_o      (col),
    .row_o      (row),
    .col_last_o (col_last),
    .last_o     (pix_last)
  );

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    width_d  = width_q;
    height_d = height_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (bus.cfg_start) begin
          if (start_ok) begin
            state_d  = StCfg;
            width_d  = bus.cfg_width;
            height_d = bus.cfg_height;
            err_d    = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StCfg: begin
        state_d = StWait;
        wait_d  = '0;
      end
      StWait: begin
        if (wait_q == WAIT_CNT_W'(WAIT_CYCLES - 1)) begin
          state_d = StRun;
        end else begin
          wait_d = wait_q + WAIT_CNT_W'(1);
        end
      end
      StRun: begin
        if (beat && pix_last) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort) begin
      state_d = StIdle;
    end
  end

  // Markers register the beat's position so they line up with delay-memory data.
  always_comb begin
    win_d = beat && (row >= DIM_WIDTH'(KERNEL - 1)) && (col >= MEM_AWIDTH'(KERNEL - 1));
    eol_d = beat && col_last;
    eof_d = beat && pix_last;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      wait_q   <= '0;
      width_q  <= '0;
      height_q <= '0;
      err_q    <= 1'b0;
      win_q    <= 1'b0;
      eol_q    <= 1'b0;
      eof_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      width_q  <= width_d;
      height_q <= height_d;
      err_q    <= err_d;
      win_q    <= win_d;
      eol_q    <= eol_d;
      eof_q    <= eof_d;
    end
  end

  assign bus.cfg_busy      = (state_q != StIdle);
  assign bus.cfg_err       = err_q;
  assign bus.up_rdy        = up_rdy;
  assign bus.mem_cfg_delay = width_q;
  assign bus.mem_cfg_set   = (state_q == StCfg);
  assign bus.mem_val       = beat;
  assign bus.col           = col;
  assign bus.row           = row;
  assign bus.win_val       = win_q;
  assign bus.eol           = eol_q;
  assign bus.eof           = eof_q;

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Self-checking bench for line_buf_ctrl: config table, reference frame model, corner sequences.
module tb_line_buf_ctrl;

  localparam int KERNEL = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  line_buf_ctrl_if #(.MEM_AWIDTH(16), .DIM_WIDTH(16)) bus ();

  line_buf_ctrl #(
    .MEM_AWIDTH(16),
    .DIM_WIDTH (16),
    .KERNEL    (KERNEL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int w;
    int h;
    bit gaps;
    bit exp_err;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the edge, outputs are sampled 1 unit later.
  task automatic drive(input bit st, input bit ab, input bit uv);
    @(posedge clk);
    #1;
    bus.cfg_start = st;
    bus.cfg_abort = ab;
    bus.up_val    = uv;
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, bus.cfg_busy, 0);
    check({tag, "_err"}, bus.cfg_err, 0);
    check({tag, "_rdy"}, bus.up_rdy, 0);
    check({tag, "_cfg_set"}, bus.mem_cfg_set, 0);
    check({tag, "_mem_val"}, bus.mem_val, 0);
    check({tag, "_win"}, bus.win_val, 0);
    check({tag, "_eol"}, bus.eol, 0);
    check({tag, "_eof"}, bus.eof, 0);
    check({tag, "_delay"}, bus.mem_cfg_delay, 0);
    check({tag, "_col"}, bus.col, 0);
    check({tag, "_row"}, bus.row, 0);
  endtask

  task automatic start_frame(input int w, input int h, input bit exp_err);
    bus.cfg_width  = 16'(w);
    bus.cfg_height = 16'(h);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    if (exp_err) begin
      check("rej_err", bus.cfg_err, 1);
      check("rej_busy", bus.cfg_busy, 0);
      check("rej_cfg_set", bus.mem_cfg_set, 0);
      drive(1'b0, 1'b0, 1'b1);
      check("rej_busy_hold", bus.cfg_busy, 0);
      check("rej_cfg_set_hold", bus.mem_cfg_set, 0);
      check("rej_mem_val", bus.mem_val, 0);
    end else begin
      check("cfg_set", bus.mem_cfg_set, 1);
      check("cfg_delay", bus.mem_cfg_delay, w);
      check("cfg_busy", bus.cfg_busy, 1);
      check("cfg_err_clr", bus.cfg_err, 0);
      check("cfg_rdy", bus.up_rdy, 0);
      drive(1'b0, 1'b0, 1'b1);
      check("wait1_cfg_set", bus.mem_cfg_set, 0);
      check("wait1_rdy", bus.up_rdy, 0);
      check("wait1_mem_val", bus.mem_val, 0);
      drive(1'b0, 1'b0, 1'b1);
      check("wait2_rdy", bus.up_rdy, 0);
      check("wait2_delay", bus.mem_cfg_delay, w);
    end
  endtask

  // Reference: beat k of a w x h frame sits at (k / w, k % w); markers follow one cycle later.
  task automatic run_frame(input int w, input int h, input bit gaps, input int start_at,
                           input int abort_at, output bit aborted);
    int k, total, budget, nw, ne, nf;
    bit ew, ee, ef, uv, st, ab;
    k = 0; total = w * h; budget = 0;
    nw = 0; ne = 0; nf = 0;
    ew = 0; ee = 0; ef = 0;
    aborted = 0;
    while (k < total) begin
      uv = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      st = (k == start_at);
      ab = (k == abort_at);
      if (st) bus.cfg_width = 16'd1;
      drive(st, ab, uv);
      check("win_val", bus.win_val, ew);
      check("eol", bus.eol, ee);
      check("eof", bus.eof, ef);
      nw += int'(bus.win_val); ne += int'(bus.eol); nf += int'(bus.eof);
      check("up_rdy", bus.up_rdy, !ab);
      check("mem_val", bus.mem_val, uv && !ab);
      if (ab) begin
        drive(1'b0, 1'b0, 1'b1);
        check("abort_busy", bus.cfg_busy, 0);
        check("abort_rdy", bus.up_rdy, 0);
        check("abort_mem_val", bus.mem_val, 0);
        check("abort_eof", bus.eof, 0);
        check("abort_eol", bus.eol, 0);
        check("abort_win", bus.win_val, 0);
        check("abort_col", bus.col, 0);
        check("abort_row", bus.row, 0);
        aborted = 1;
        return;
      end
      if (uv) begin
        check("col", bus.col, k % w);
        check("row", bus.row, k / w);
        ew = (k / w >= KERNEL - 1) && (k % w >= KERNEL - 1);
        ee = (k % w == w - 1);
        ef = (k == total - 1);
        k++;
      end else begin
        ew = 0; ee = 0; ef = 0;
      end
      budget++;
      if (budget > 20 * total + 20) begin
        check("beat_budget", k, total);
        return;
      end
    end
    drive(1'b0, 1'b0, 1'b1);
    check("done_win", bus.win_val, ew);
    check("done_eol", bus.eol, ee);
    check("done_eof", bus.eof, ef);
    nw += int'(bus.win_val); ne += int'(bus.eol); nf += int'(bus.eof);
    check("done_rdy", bus.up_rdy, 0);
    check("done_mem_val", bus.mem_val, 0);
    check("done_busy", bus.cfg_busy, 1);
    drive(1'b0, 1'b0, 1'b1);
    check("idle_busy", bus.cfg_busy, 0);
    check("idle_rdy", bus.up_rdy, 0);
    check("idle_markers", {bus.win_val, bus.eol, bus.eof}, 0);
    check("cnt_win", nw, (h - KERNEL + 1) * (w - KERNEL + 1));
    check("cnt_eol", ne, h);
    check("cnt_eof", nf, 1);
    check("frame_err", bus.cfg_err, 0);
  endtask

  initial begin
    bit ab;
    tbl[0] = '{4, 3, 1'b0, 1'b0};
    tbl[1] = '{2, 3, 1'b0, 1'b1};
    tbl[2] = '{5, 4, 1'b1, 1'b0};
    tbl[3] = '{4, 0, 1'b0, 1'b1};
    tbl[4] = '{3, 3, 1'b0, 1'b0};
    tbl[5] = '{3, 2, 1'b0, 1'b1};
    tbl[6] = '{5, 4, 1'b0, 1'b0};
    tbl[7] = '{6, 5, 1'b1, 1'b0};

    bus.cfg_width  = '0;
    bus.cfg_height = '0;
    bus.cfg_start  = 1'b0;
    bus.cfg_abort  = 1'b0;
    bus.up_val     = 1'b1;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_all_zero("reset");
    @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      start_frame(tbl[i].w, tbl[i].h, tbl[i].exp_err);
      if (!tbl[i].exp_err) run_frame(tbl[i].w, tbl[i].h, tbl[i].gaps, -1, -1, ab);
    end

    // Abort at (row1, col2), then a clean restart.
    start_frame(4, 3, 1'b0);
    run_frame(4, 3, 1'b0, -1, 6, ab);
    check("abort_taken", ab, 1);
    start_frame(4, 3, 1'b0);
    run_frame(4, 3, 1'b0, -1, -1, ab);

    // Invalid start while running must be ignored.
    start_frame(5, 4, 1'b0);
    run_frame(5, 4, 1'b1, 7, -1, ab);

    // Asynchronous reset mid-frame.
    start_frame(4, 3, 1'b0);
    repeat (5) drive(1'b0, 1'b0, 1'b1);
    check("pre_rst_busy", bus.cfg_busy, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check_all_zero("midrst");
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) drive(1'b0, 1'b0, 1'b1);
    check("post_rst_busy", bus.cfg_busy, 0);
    check("post_rst_rdy", bus.up_rdy, 0);
    start_frame(4, 3, 1'b0);
    run_frame(4, 3, 1'b0, -1, -1, ab);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/line_buf_ctrl.md
# line_buf_ctrl

Frame sequencer for a bank of row-delay memories feeding a KERNEL×KERNEL filter. Configures all delay memories with the row width, gates the pixel stream into them, and tracks column/row position. Emits a window-valid flag, end-of-line and end-of-frame markers aligned with the delay-memory outputs. Sits between the pixel source and the line-buffer/filter datapath, one instance per filter.

## Interface
- MEM_AWIDTH, 16, delay-memory address width; row width field width
- DIM_WIDTH, 16, row-counter/height width
- KERNEL, 3, filter kernel size; rows/cols needed before a window is valid (≥2)

- clk  in  1  clock, all logic rising-edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- cfg_width  in  MEM_AWIDTH  pixels per row, sampled on accepted cfg_start
- cfg_height  in  DIM_WIDTH  rows per frame, sampled on accepted cfg_start
- cfg_start  in  1  one-cycle pulse: begin a frame
- cfg_abort  in  1  one-cycle pulse: terminate current frame
- cfg_busy  out  1  high from accepted cfg_start until return to IDLE
- cfg_err  out  1  sticky: last cfg_start rejected
- up_val  in  1  source pixel valid
- up_rdy  out  1  controller accepts pixels (RUN only)
- mem_cfg_delay  out  MEM_AWIDTH  broadcast delay to delay memories (= row width)
- mem_cfg_set  out  1  one-cycle config strobe to delay memories
- mem_val  out  1  pixel write/advance strobe to delay memories, = up_val & up_rdy (combinational)
- col  out  MEM_AWIDTH  column of current accepted pixel
- row  out  DIM_WIDTH  row of current accepted pixel
- win_val  out  1  full KERNEL window available at delay-memory outputs
- eol  out  1  last pixel of a row, aligned with win_val timing
- eof  out  1  last pixel of frame, aligned with win_val timing

## Operation
- States: IDLE, CFG, WAIT, RUN, DONE.
- IDLE: cfg_start with cfg_width ≥ KERNEL and cfg_height ≥ KERNEL → latch both, clear cfg_err, go CFG. Otherwise set cfg_err and stay IDLE.
- CFG: mem_cfg_set=1 for exactly this cycle; mem_cfg_delay holds the latched width from CFG onward. Go WAIT.
- WAIT: 2 cycles, covering the delay memories' registered config and pointer reset. Then go RUN.
- RUN: up_rdy=1. Each beat with mem_val=1:
  - col increments; at col == width−1, col→0 and row increments.
  - At row == height−1 and col == width−1, go DONE.
- DONE: one cycle, up_rdy=0, then IDLE.
- cfg_busy = (state != IDLE).
- cfg_start while busy is ignored and does not touch cfg_err.
- cfg_abort in any non-IDLE state → IDLE next cycle. up_rdy drops that cycle; counters clear; no eof.
- cfg_abort and cfg_start in the same IDLE cycle: cfg_start wins.
- col/row clear to 0 on entry to CFG.
- Width arithmetic: compare against width−1 computed in MEM_AWIDTH bits. cfg_width ≥ KERNEL guarantees no underflow.

## Timing
- Reset: state IDLE. cfg_busy, cfg_err, up_rdy, mem_cfg_set, mem_val, win_val, eol, eof all 0. mem_cfg_delay, col, row all 0.
- cfg_start accepted at edge N:
  - mem_cfg_set high in cycle N+1.
  - WAIT in cycles N+2 and N+3.
  - up_rdy high from cycle N+4.
- win_val/eol/eof are registered, high in the cycle after the accepting beat, matching delay-memory data latency.
  - win_val = prior beat had row ≥ KERNEL−1 and col ≥ KERNEL−1.
  - eol = prior beat had col == width−1.
  - eof = eol on the last row.
- Markers pulse one cycle per beat. They are 0 in cycles with no accepted beat.
- Final beat at edge M: eof high in cycle M+1; state DONE in cycle M+1; IDLE and cfg_busy=0 in cycle M+2.
- Earliest next cfg_start acceptance: edge ending cycle M+2.
- Async reset mid-frame: immediate return to reset values, no handshake.

## Structure
- Package line_buf_pkg: state enum (IDLE, CFG, WAIT, RUN, DONE), WAIT_CYCLES=2.
- Sub-module pix_pos_cnt: col/row counter with wrap and last-pixel flag, parameterised by MEM_AWIDTH/DIM_WIDTH. FSM stays in the top.

## Test plan
- Width 4, height 3, KERNEL 3, continuous up_val:
  - mem_cfg_set pulses once with delay 4; up_rdy rises 3 cycles after that pulse.
  - 12 beats accepted; win_val high for beats (row2,col2) and (row2,col3) only.
  - eol ×3, eof once on beat 12.
- Random up_val gaps with width 5, height 4: col/row sequence and marker count are identical to the gap-free run; no marker is asserted in an idle cycle.
- cfg_width 2 or cfg_height 0: cfg_err=1, cfg_busy stays 0, no mem_cfg_set. A following valid start clears cfg_err.
- cfg_abort during RUN at (row1,col2): IDLE next cycle, up_rdy=0, no eof. A restart then begins at (row0,col0) with a fresh mem_cfg_set.
- cfg_start during RUN: ignored, frame completes normally, cfg_err unchanged.
- rst asserted mid-frame for 1 cycle: all outputs 0 immediately; cfg_busy stays 0 until the next cfg_start.
